// File: rtl/lsu_bus_adapter.sv
// rtl/lsu_bus_adapter.sv - load/store unit to word-aligned req/gnt/rvalid data bus
// Build option LSU_MISALIGN_TRAP_EN: reject misaligned accesses instead of force-aligning them.
module lsu_bus_adapter #(
  parameter int Width          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd,
  input  logic               st_en,
  input  logic               LB,
  input  logic               LH,
  input  logic               LBU,
  input  logic               LHU,
  input  logic               SB,
  input  logic               SH,
  input  logic [Width-1:0]   addr,
  input  logic [Width-1:0]   wdata,
  output logic [Width-1:0]   ld_data,
  output logic               stall,
  output logic               misalign,
  output logic               bus_err,
  output logic               bus_req,
  output logic               bus_we,
  output logic [Width-1:0]   bus_addr,
  output logic [Width/8-1:0] bus_be,
  output logic [Width-1:0]   bus_wdata,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [Width-1:0]   bus_rdata
);
  localparam int BEW = Width / 8;
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;

  logic             req, is_byte, is_half, mis_raw, trap, cnt_hit;
  logic [1:0]       off, off_q;
  logic             byte_q, half_q, sign_q;
  logic [CW-1:0]    cnt;
  logic [BEW-1:0]   be_n;
  logic [Width-1:0] wdata_n, rdata_fmt;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  assign req     = st_en | mem_rd;
  assign is_byte = LB | LBU | SB;
  assign is_half = ~is_byte & (LH | LHU | SH);
  assign mis_raw = (is_half & addr[0]) | (~is_byte & ~is_half & (addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = mis_raw;
  assign off  = addr[1:0];
`else
  // Offending low bits are dropped so the access proceeds naturally aligned.
  assign trap = 1'b0;
  assign off  = is_byte ? addr[1:0] : (is_half ? {addr[1], 1'b0} : 2'b00);
`endif

  assign cnt_hit = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_n    = '1;
    wdata_n = wdata;
    if (is_byte) begin
      be_n    = BEW'(1) << off;
      wdata_n = {BEW{wdata[7:0]}};
    end else if (is_half) begin
      be_n    = off[1] ? BEW'(4'b1100) : BEW'(4'b0011);
      wdata_n = {(BEW/2){wdata[15:0]}};
    end
  end

  assign rd_byte = bus_rdata[{off_q, 3'b000} +: 8];
  assign rd_half = bus_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    rdata_fmt = bus_rdata;
    if (byte_q)
      rdata_fmt = {{(Width-8){sign_q & rd_byte[7]}}, rd_byte};
    else if (half_q)
      rdata_fmt = {{(Width-16){sign_q & rd_half[15]}}, rd_half};
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      IDLE: if (req && !trap) begin
        stall   = 1'b1;
        state_n = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt) state_n = (bus_we || bus_rvalid) ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid || cnt_hit) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      ld_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      cnt       <= '0;
      off_q     <= 2'b00;
      byte_q    <= 1'b0;
      half_q    <= 1'b0;
      sign_q    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          if (trap) begin
            misalign <= 1'b1;
          end else begin
            bus_req   <= 1'b1;
            bus_we    <= st_en;
            bus_addr  <= {addr[Width-1:2], 2'b00};
            bus_be    <= be_n;
            bus_wdata <= wdata_n;
            off_q     <= off;
            byte_q    <= is_byte;
            half_q    <= is_half;
            sign_q    <= is_byte ? LB : LH;
          end
        end
        REQ: if (bus_gnt) begin
          bus_req <= 1'b0;
          if (!bus_we && bus_rvalid) ld_data <= rdata_fmt;
        end
        // rvalid wins over a timeout landing in the same cycle.
        WAIT: begin
          if (bus_rvalid) begin
            ld_data <= rdata_fmt;
          end else if (cnt_hit) begin
            ld_data <= '0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb/tb_lsu_bus_adapter.sv - randomized self-checking bench for lsu_bus_adapter
module tb_lsu_bus_adapter;
  localparam int W  = 32;
  localparam int TO = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic mem_rd = 0, st_en = 0, LB = 0, LH = 0, LBU = 0, LHU = 0, SB = 0, SH = 0;
  logic [31:0] addr = 0, wdata = 0, bus_rdata = 0;
  logic bus_gnt = 0, bus_rvalid = 0;
  logic [31:0] ld_data, bus_addr, bus_wdata;
  logic stall, misalign, bus_err, bus_req, bus_we;
  logic [3:0] bus_be;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_bus_adapter #(.Width(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .st_en(st_en),
    .LB(LB), .LH(LH), .LBU(LBU), .LHU(LHU), .SB(SB), .SH(SH),
    .addr(addr), .wdata(wdata), .ld_data(ld_data), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    mem_rd = 0; st_en = 0; LB = 0; LH = 0; LBU = 0; LHU = 0; SB = 0; SH = 0;
  endtask

  // sz: 0 byte, 1 half, 2 word. Called and returns just after a rising edge, DUT idle.
  task automatic access(input bit st, input bit ld, input int sz, input bit sgn, input bit extra,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rd);
    bit mis, tmo, done;
    logic [31:0] ea, xbe, xwd, xld, v;
    int lane, xstall, nst;
    mis = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
    ea = a;
    if (sz == 1) ea[0] = 1'b0;
    if (sz == 2) ea[1:0] = 2'b00;
    lane = int'(ea[1:0]);
    xbe = (sz == 0) ? (32'd1 << lane) : (sz == 1) ? (32'd3 << lane) : 32'hF;
    xwd = (sz == 0) ? 32'(wd[7:0]) * 32'h01010101 :
          (sz == 1) ? 32'(wd[15:0]) * 32'h00010001 : wd;
    v = rd >> (8 * lane);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end
    tmo = !st && rdly > TO;
    xld = tmo ? 32'h0 : v;
    xstall = 2 + gdly + (st ? 0 : (tmo ? TO : rdly));

    st_en = st; mem_rd = ld; addr = a; wdata = wd;
    if (sz == 0) begin
      if (st) SB = 1; else if (sgn) LB = 1; else LBU = 1;
      if (extra) LH = 1;
    end else if (sz == 1) begin
      if (st) SH = 1; else if (sgn) LH = 1; else LHU = 1;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      @(negedge clk);
      chk("mis_stall", 32'(stall), 32'd0);
      @(posedge clk); #1; clear_req();
      @(negedge clk);
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_noreq", 32'(bus_req), 32'd0);
      chk("mis_nostall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mis_once", 32'(misalign), 32'd0);
      @(posedge clk); #1;
      return;
    end
`endif

    nst = 0; done = 0;
    @(negedge clk);
    chk("idle_stall", 32'(stall), 32'd1);
    if (stall) nst++;
    for (int n = 0; n < 30 && !done; n++) begin
      @(posedge clk); #1;
      bus_gnt    = (n == gdly);
      bus_rvalid = !st && (n == gdly + rdly);
      bus_rdata  = bus_rvalid ? rd : $urandom;
      @(negedge clk);
      if (n == 0 || n == gdly) begin
        chk("req", 32'(bus_req), 32'd1);
        chk("we", 32'(bus_we), 32'(st));
        chk("addr", bus_addr, {ea[31:2], 2'b00});
        chk("be", 32'(bus_be), xbe);
        if (st) chk("wdata", bus_wdata, xwd);
      end
      if (stall) nst++;
      else begin
        done = 1;
        chk("stall_cycles", nst, xstall);
        chk("done_req", 32'(bus_req), 32'd0);
        chk("bus_err", 32'(bus_err), 32'(tmo));
        chk("misalign_off", 32'(misalign), 32'd0);
        if (!st) chk("ld_data", ld_data, xld);
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    clear_req(); bus_gnt = 0; bus_rvalid = 0;
    @(negedge clk);
    chk("err_once", 32'(bus_err), 32'd0);
    chk("idle_nostall", 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ld", ld_data, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_err", 32'(bus_err) | 32'(misalign), 32'd0);
    @(posedge clk); #1;

    access(1, 0, 0, 0, 0, 32'h1003, 32'h000000A5, 0, 0, 32'h0);
    access(0, 1, 0, 1, 0, 32'h2002, 32'h0, 0, 2, 32'h00800000);
    access(0, 1, 0, 0, 0, 32'h2002, 32'h0, 0, 2, 32'h00800000);
    access(0, 1, 1, 1, 0, 32'h3002, 32'h0, 0, 0, 32'h80011234);
    access(0, 1, 1, 0, 0, 32'h3002, 32'h0, 0, 0, 32'h80011234);
    access(0, 1, 2, 0, 0, 32'h4001, 32'h0, 1, 1, 32'hCAFEF00D);
    access(0, 1, 2, 0, 0, 32'h5000, 32'h0, 0, TO + 3, 32'h12345678);

    // Late rvalid after a timeout must not disturb anything.
    bus_rvalid = 1; bus_gnt = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("late_stall", 32'(stall), 32'd0);
    @(posedge clk); #1; bus_rvalid = 0; bus_gnt = 0;
    @(negedge clk);
    chk("late_ld", ld_data, 32'd0);
    chk("late_req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;

    // k=0: reset while REQ waits for gnt; k=1: reset while WAIT.
    for (int k = 0; k < 2; k++) begin
      mem_rd = 1; addr = 32'h7000;
      @(posedge clk); #1;
      if (k == 1) begin
        bus_gnt = 1;
        @(posedge clk); #1;
        bus_gnt = 0;
      end
      @(negedge clk);
      chk("pre_rst_stall", 32'(stall), 32'd1);
      clear_req(); rst = 1;
      #1;
      chk("rst_mid_req", 32'(bus_req), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      @(posedge clk); #1; rst = 0;
      bus_rvalid = 1; bus_gnt = 1;
      @(negedge clk);
      chk("post_rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1; bus_rvalid = 0; bus_gnt = 0;
      @(negedge clk);
      chk("post_rst_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
    end
    access(1, 0, 2, 0, 0, 32'h6000, 32'h13579BDF, 0, 0, 32'h0);

    for (int i = 0; i < 150; i++) begin
      bit st, ld;
      st = 1'($urandom_range(0, 1));
      ld = st ? 1'($urandom_range(0, 1)) : 1'b1;
      access(st, ld, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Load/store unit that consumes the main controller's memory-access decode: st_en, LB, LH, LBU, LHU, SB, SH, plus a load-enable qualifier.
- Converts each access into one word-aligned data-bus transaction with a req/gnt/rvalid handshake.
- Formats load data (byte/half extraction, sign or zero extension) and stalls the core until the access completes.
- Sits between the execute stage (ALU address, rs2 data) and the data-memory bus.

Parameters:
Width, 32, datapath/address width; byte-enable width is Width/8
TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before aborting; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
mem_rd  in  1  load request (load opcode decoded)
st_en  in  1  store request
LB, LH, LBU, LHU, SB, SH  in  1 each  size/sign flags from main controller; none set = word
addr  in  Width  effective byte address from ALU
wdata  in  Width  store data (rs2)
ld_data  out  Width  formatted load result; valid in DONE
stall  out  1  freeze pipeline while access in progress
misalign  out  1  one-cycle pulse, misaligned access rejected
bus_err  out  1  one-cycle pulse, load response timeout
bus_req  out  1  bus request, registered
bus_we  out  1  1 = write
bus_addr  out  Width  word address (bits [1:0] = 0)
bus_be  out  Width/8  byte enables
bus_wdata  out  Width  lane-aligned write data
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  read data valid
bus_rdata  in  Width  read word

Behaviour:
- Reset (async, active high): state IDLE; bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_data, misalign, bus_err, timeout counter all 0. Reset mid-transaction drops bus_req immediately; any later rvalid/gnt is ignored while in IDLE.
- Request priority:
  - st_en over mem_rd when both are set.
  - Size decode: byte (LB/LBU/SB) over half (LH/LHU/SH) over word.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - With an aligned request: latch bus_addr = {addr[Width-1:2], 2'b00}, bus_be, bus_wdata and bus_we; set bus_req = 1; go to REQ. stall = 1 combinationally in this cycle.
  - With a misaligned request: misalign = 1 for one cycle, no bus activity, stall = 0, remain in IDLE.
- REQ:
  - bus_req, address, byte enables and data held stable until bus_gnt.
  - On gnt: bus_req = 0 next cycle. A store goes to DONE. A load goes to WAIT, or directly to DONE if bus_rvalid is high in the same cycle (data captured).
  - No timeout in REQ.
- WAIT:
  - On bus_rvalid: capture formatted data into ld_data and go to DONE.
  - Timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES without rvalid: bus_err = 1 for one cycle, ld_data = 0, go to DONE. A late rvalid is then ignored.
- DONE: stall = 0 for exactly one cycle, so the pipeline advances and writes back ld_data; counter cleared; go to IDLE.
- stall = (IDLE & aligned request) | REQ | WAIT.
- Minimum stall: store 2 cycles, load 2 cycles (gnt and rvalid together) or 3 cycles.
- Byte-lane rules (off = addr[1:0]):
  - Byte: be = 1 << off; bus_wdata = wdata[7:0] replicated to all 4 lanes.
  - Half: be = off[1] ? 4'b1100 : 4'b0011; wdata[15:0] replicated to both half-lanes.
  - Word: be = 4'b1111; wdata as-is.
- Load format:
  - LB/LBU: byte at lane off, sign-/zero-extended to Width.
  - LH/LHU: half at off[1], sign-/zero-extended.
  - Word: bus_rdata unchanged.
- bus_we = 0 for loads; bus_be is still driven for loads.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: misaligned accesses are rejected with a misalign pulse, as above.
- Undefined: misalign tied to 0. The offending low address bits are forced to natural alignment (half: addr[0] = 0; word: addr[1:0] = 0) and the access proceeds normally.

Test Plan:
- SB: addr=0x1003, wdata=0x000000A5, gnt in first REQ cycle -> bus_addr=0x1000, bus_be=4'b1000, bus_wdata=0xA5A5A5A5, bus_we=1, stall high 2 cycles then low 1 cycle.
- LB: addr=0x2002, bus_rdata=0x00800000, rvalid 2 cycles after gnt -> ld_data=0xFFFFFF80 in DONE. Repeat with LBU -> 0x00000080.
- LH: addr=0x3002, bus_rdata=0x8001_1234, gnt and rvalid in same cycle -> ld_data=0xFFFF8001, 2-cycle stall. LHU -> 0x00008001.
- LW: addr=0x4001 with LSU_MISALIGN_TRAP_EN -> misalign pulse, bus_req never asserted, stall=0. Without the macro -> bus_addr=0x4000, be=4'b1111.
- LW: addr=0x5000 with TIMEOUT_CYCLES=4 and no rvalid -> bus_err pulses after 4 WAIT cycles, ld_data=0, DONE, then IDLE; a later rvalid is ignored.
- Assert rst while in WAIT -> bus_req=0 and stall=0 immediately, state IDLE. Next aligned SW at 0x6000 completes normally.
